// File: rtl/fp_operand_stage.sv
// fp_operand_stage
// ----------------
// Registered operand-unpack stage in front of the FP add/sub core.
// Each accepted beat (a, b, operation_select) is split into sign,
// biased exponent and hidden-bit mantissa per operand, classified, and
// NaN/Inf/Zero special results are resolved before the core sees them.
// A one-entry skid buffer behind the output register keeps full
// throughput under backpressure while in_ready stays purely registered.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is a flop output)
//   a, b                IEEE 754 single-precision operands
//   operation_select    0 = a+b, 1 = a-b
//   out_valid/out_ready downstream handshake
//   sign_a, sign_b_eff  sign of a; sign of b folded with the operation
//   exp_a, exp_b        biased exponents (denormals reported as 1)
//   mant_a, mant_b      {hidden bit, fraction}
//   class_a, class_b    0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 QNAN, 5 SNAN
//   eff_sub             effective subtraction
//   special_valid       special_result is final, core bypassed
//   special_result      early result (0 when special_valid is 0)
//   invalid             IEEE invalid-operation flag

// Per-operand field split and classification.
module fp_operand_decode #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic [WIDTH-1:0]    operand,
    input  logic                flip_sign,
    output logic                sign,
    output logic [EXP_BITS-1:0] exp,
    output logic [MANT_BITS:0]  mant,
    output logic [2:0]          cls
);
    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_DENORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    logic [EXP_BITS-1:0]  exp_f;
    logic [MANT_BITS-1:0] frac;
    logic                 exp_zero;
    logic                 exp_ones;
    logic                 frac_zero;

    assign exp_f     = operand[WIDTH-2 -: EXP_BITS];
    assign frac      = operand[MANT_BITS-1:0];
    assign exp_zero  = (exp_f == '0);
    assign exp_ones  = (exp_f == '1);
    assign frac_zero = (frac == '0);

    assign sign = operand[WIDTH-1] ^ flip_sign;
    // Denormals share the minimum normal exponent so the core can align
    // them without a separate path; true zero keeps its field value.
    assign exp  = (exp_zero && !frac_zero) ? EXP_BITS'(1) : exp_f;
    assign mant = {!exp_zero, frac};

    always_comb begin
        cls = CLS_NORMAL;
        if (exp_zero) begin
            cls = frac_zero ? CLS_ZERO : CLS_DENORM;
        end else if (exp_ones) begin
            if (frac_zero)               cls = CLS_INF;
            else if (frac[MANT_BITS-1])  cls = CLS_QNAN;
            else                         cls = CLS_SNAN;
        end
    end
endmodule

module fp_operand_stage #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 operation_select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign_a,
    output logic                 sign_b_eff,
    output logic [EXP_BITS-1:0]  exp_a,
    output logic [EXP_BITS-1:0]  exp_b,
    output logic [MANT_BITS:0]   mant_a,
    output logic [MANT_BITS:0]   mant_b,
    output logic [2:0]           class_a,
    output logic [2:0]           class_b,
    output logic                 eff_sub,
    output logic                 special_valid,
    output logic [WIDTH-1:0]     special_result,
    output logic                 invalid
);
    localparam int NUM_OPS = 2;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    // Handshake state is {out_valid, skid_valid}; (0,1) is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam logic [WIDTH-1:0] QNAN_DEFAULT =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

    typedef struct packed {
        logic                sign_a;
        logic                sign_b_eff;
        logic [EXP_BITS-1:0] exp_a;
        logic [EXP_BITS-1:0] exp_b;
        logic [MANT_BITS:0]  mant_a;
        logic [MANT_BITS:0]  mant_b;
        logic [2:0]          class_a;
        logic [2:0]          class_b;
        logic                eff_sub;
        logic                special_valid;
        logic [WIDTH-1:0]    special_result;
        logic                invalid;
    } beat_t;

    // ---------------- operand decode ----------------
    logic [NUM_OPS-1:0][WIDTH-1:0]    opnd;
    logic [NUM_OPS-1:0]               flip;
    logic [NUM_OPS-1:0]               sgn;
    logic [NUM_OPS-1:0][EXP_BITS-1:0] expv;
    logic [NUM_OPS-1:0][MANT_BITS:0]  mantv;
    logic [NUM_OPS-1:0][2:0]          clsv;

    assign opnd = {b, a};
    assign flip = {operation_select, 1'b0};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_dec
        fp_operand_decode #(
            .WIDTH    (WIDTH),
            .EXP_BITS (EXP_BITS),
            .MANT_BITS(MANT_BITS)
        ) u_dec (
            .operand  (opnd[i]),
            .flip_sign(flip[i]),
            .sign     (sgn[i]),
            .exp      (expv[i]),
            .mant     (mantv[i]),
            .cls      (clsv[i])
        );
    end

    // ---------------- special-case resolution ----------------
    logic  any_nan, any_snan, inf_a, inf_b, zero_a, zero_b, esub;
    beat_t dec_beat;

    assign any_snan = (clsv[0] == CLS_SNAN) || (clsv[1] == CLS_SNAN);
    assign any_nan  = any_snan || (clsv[0] == CLS_QNAN) || (clsv[1] == CLS_QNAN);
    assign inf_a    = (clsv[0] == CLS_INF);
    assign inf_b    = (clsv[1] == CLS_INF);
    assign zero_a   = (clsv[0] == CLS_ZERO);
    assign zero_b   = (clsv[1] == CLS_ZERO);
    assign esub     = sgn[0] ^ sgn[1];

    always_comb begin
        dec_beat                = '0;
        dec_beat.sign_a         = sgn[0];
        dec_beat.sign_b_eff     = sgn[1];
        dec_beat.exp_a          = expv[0];
        dec_beat.exp_b          = expv[1];
        dec_beat.mant_a         = mantv[0];
        dec_beat.mant_b         = mantv[1];
        dec_beat.class_a        = clsv[0];
        dec_beat.class_b        = clsv[1];
        dec_beat.eff_sub        = esub;
        // First match wins: NaN, Inf-Inf, single Inf, double zero.
        if (any_nan) begin
            dec_beat.special_valid  = 1'b1;
            dec_beat.special_result = QNAN_DEFAULT;
            dec_beat.invalid        = any_snan;
        end else if (inf_a && inf_b && esub) begin
            dec_beat.special_valid  = 1'b1;
            dec_beat.special_result = QNAN_DEFAULT;
            dec_beat.invalid        = 1'b1;
        end else if (inf_a || inf_b) begin
            // Both-Inf here implies equal effective signs, so a's sign works.
            dec_beat.special_valid  = 1'b1;
            dec_beat.special_result = {inf_a ? sgn[0] : sgn[1], {EXP_BITS{1'b1}},
                                       {MANT_BITS{1'b0}}};
        end else if (zero_a && zero_b) begin
            // Round-to-nearest: result is -0 only when both are -0.
            dec_beat.special_valid  = 1'b1;
            dec_beat.special_result = {sgn[0] & sgn[1], {(WIDTH-1){1'b0}}};
        end
    end

    // ---------------- output register + skid ----------------
    beat_t out_q, out_d, skid_q, skid_d;
    logic  out_valid_q, out_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  in_ready_q;
    logic  take, accept;

    assign take   = out_valid_q & out_ready;
    assign accept = in_valid & in_ready_q;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        case ({out_valid_q, skid_valid_q})
            ST_EMPTY: begin
                if (accept) begin
                    out_d       = dec_beat;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (take && accept) begin
                    out_d = dec_beat;
                end else if (take) begin
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    skid_d       = dec_beat;
                    skid_valid_d = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no accept can coincide.
                if (take) begin
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d  = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            // Registered copy of !skid_valid: no out_ready -> in_ready path.
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign sign_a         = out_q.sign_a;
    assign sign_b_eff     = out_q.sign_b_eff;
    assign exp_a          = out_q.exp_a;
    assign exp_b          = out_q.exp_b;
    assign mant_a         = out_q.mant_a;
    assign mant_b         = out_q.mant_b;
    assign class_a        = out_q.class_a;
    assign class_b        = out_q.class_b;
    assign eff_sub        = out_q.eff_sub;
    assign special_valid  = out_q.special_valid;
    assign special_result = out_q.special_result;
    assign invalid        = out_q.invalid;
endmodule

// File: tb/tb_fp_operand_stage.sv
// Scoreboard bench for fp_operand_stage: stimulus pushes reference-model
// results, a monitor pops and compares on every output transfer.
module tb_fp_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        operation_select = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_a, sign_b_eff, eff_sub, special_valid, invalid;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [2:0]  class_a, class_b;
    logic [31:0] special_result;

    int checks = 0;
    int failures = 0;
    int or_mode = 1;            // 0: hold low, 1: hold high, 2: random
    logic [106:0] sb_q[$];

    logic [31:0] dir_a  [8] = '{32'h3F800000, 32'h7F800000, 32'h7F800001, 32'h7FC00000,
                                32'h80000000, 32'h00000001, 32'h7F800000, 32'hFF800000};
    logic [31:0] dir_b  [8] = '{32'h40000000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
                                32'h00000000, 32'h3F800000, 32'hFF800000, 32'h3F800000};
    logic        dir_op [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    fp_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .operation_select(operation_select),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_a(sign_a), .sign_b_eff(sign_b_eff), .exp_a(exp_a), .exp_b(exp_b),
        .mant_a(mant_a), .mant_b(mant_b), .class_a(class_a), .class_b(class_b),
        .eff_sub(eff_sub), .special_valid(special_valid),
        .special_result(special_result), .invalid(invalid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [2:0] classify(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == 8'd0)   return (f == 23'd0) ? 3'd0 : 3'd1;
        if (e == 8'd255) begin
            if (f == 23'd0)         return 3'd3;
            if (f >= 23'h400000)    return 3'd4;
            return 3'd5;
        end
        return 3'd2;
    endfunction

    function automatic logic [106:0] model(input logic [31:0] x, input logic [31:0] y,
                                           input logic op);
        logic        sa, sb, sv, inv;
        logic [2:0]  ca, cb;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic [31:0] res;
        sa = x[31];
        sb = y[31] ^ op;
        ca = classify(x);
        cb = classify(y);
        ea = (ca == 3'd1) ? 8'd1 : x[30:23];
        eb = (cb == 3'd1) ? 8'd1 : y[30:23];
        ma = {(x[30:23] != 8'd0), x[22:0]};
        mb = {(y[30:23] != 8'd0), y[22:0]};
        sv = 1'b1; inv = 1'b0; res = 32'h0;
        if (ca >= 3'd4 || cb >= 3'd4) begin
            res = 32'h7FC00000;
            inv = (ca == 3'd5) || (cb == 3'd5);
        end else if (ca == 3'd3 && cb == 3'd3 && sa != sb) begin
            res = 32'h7FC00000;
            inv = 1'b1;
        end else if (ca == 3'd3) begin
            res = sa ? 32'hFF800000 : 32'h7F800000;
        end else if (cb == 3'd3) begin
            res = sb ? 32'hFF800000 : 32'h7F800000;
        end else if (ca == 3'd0 && cb == 3'd0) begin
            res = (sa && sb) ? 32'h80000000 : 32'h0;
        end else begin
            sv = 1'b0;
        end
        return {sa, sb, ea, eb, ma, mb, ca, cb, sa ^ sb, sv, res, inv};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [31:0] s, f;
        s = 32'($urandom_range(0, 1)) << 31;
        f = $urandom & 32'h007FFFFF;
        case ($urandom_range(0, 6))
            0:       return s;
            1:       return s | f | 32'h1;
            2, 3:    return s | (32'($urandom_range(1, 254)) << 23) | f;
            4:       return s | 32'h7F800000;
            5:       return s | 32'h7FC00000 | f;
            default: return s | 32'h7F800000 | (f & 32'h003FFFFF) | 32'h1;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic op);
        int  n = 0;
        bit  done = 0;
        a = xa; b = xb; operation_select = op; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    checks++; failures++;
                    $display("FAIL send_timeout actual=stalled expected=accept");
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        sb_q.push_back(model(xa, xb, op));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        or_mode = 1;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [106:0] act, exp;
        if (rst_n && out_valid && out_ready) begin
            act = {sign_a, sign_b_eff, exp_a, exp_b, mant_a, mant_b, class_a, class_b,
                   eff_sub, special_valid, special_result, invalid};
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected actual=%h expected=none", act);
            end else begin
                exp = sb_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL beat actual=%h expected=%h", act, exp);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        or_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_special_result", special_result, 32'd0);
        chk("rst_exp_a", 32'(exp_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // directed operands from the plan, back-to-back
        or_mode = 1;
        for (int i = 0; i < 8; i++) send(dir_a[i], dir_b[i], dir_op[i]);
        drain();

        // randomized operands with random gaps and random backpressure
        or_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(gen_operand(), gen_operand(), 1'($urandom_range(0, 1)));
        end
        drain();

        // backpressure: fill output + skid, then a third beat waits
        or_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(32'h3F800000, 32'h40000000, 1'b0);
        send(32'h40400000, 32'hC0800000, 1'b1);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_exp_a", 32'(exp_a), 32'd127);
        fork
            send(32'h00000001, 32'h80000000, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 or_mode = 1;
            end
        join
        drain();

        // reset while FULL discards both held beats
        or_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(32'h3F800000, 32'h3F800000, 1'b0);
        send(32'h7F800000, 32'h00000000, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_mant_a", 32'(mant_a), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(32'hC1200000, 32'h41200000, 1'b1);
        @(negedge clk);
        chk("postrst_latency", 32'(out_valid), 32'd1);
        drain();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL leftover actual=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_operand_stage.md
# fp_operand_stage

Registered operand-unpack stage directly upstream of the floating-point adder/subtractor core. Accepts two IEEE 754 single-precision operands and an operation select over a valid/ready handshake. Splits each operand into sign, exponent and hidden-bit mantissa, classifies it, and resolves special-case results (NaN, infinity, zero) early. Delivers one registered beat per accepted input, with a skid buffer so full throughput is held under backpressure.

## Interface
- WIDTH, 32: operand width in bits; only 32 is supported.
- EXP_BITS, 8: exponent field width, taken from global_params.
- MANT_BITS, 23: stored mantissa width, taken from global_params.

- clk  input  1  clock. All state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- a, b  input  WIDTH  operands.
- operation_select  input  1  0 = a+b, 1 = a−b.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- sign_a, sign_b_eff  output  1  sign of a; sign of b XOR operation_select.
- exp_a, exp_b  output  EXP_BITS  biased exponents. A denormal is reported as 1.
- mant_a, mant_b  output  MANT_BITS+1  mantissa with the hidden bit prepended. The hidden bit is 1 for normal operands, 0 for zero or denormal.
- class_a, class_b  output  3  operand class: 0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 QNAN, 5 SNAN.
- eff_sub  output  1  sign_a XOR sign_b_eff.
- special_valid  output  1  special_result is final; the core is bypassed.
- special_result  output  WIDTH  early result. Zero when special_valid is 0.
- invalid  output  1  IEEE invalid-operation flag.

## Operation
- Decode per operand:
  - exponent 0 and fraction 0 → ZERO.
  - exponent 0 and fraction ≠0 → DENORM.
  - exponent 255 and fraction 0 → INF.
  - exponent 255 and fraction MSB 1 → QNAN.
  - exponent 255 and fraction MSB 0 with fraction ≠0 → SNAN.
  - otherwise → NORMAL.
- Special-case priority, first match wins:
  1. Either operand is QNAN or SNAN → special_result 0x7FC00000. invalid = 1 if either operand is SNAN.
  2. Both operands INF and eff_sub = 1 → special_result 0x7FC00000, invalid = 1.
  3. Exactly one operand INF, or both INF with eff_sub = 0 → special_result is infinity carrying that operand's effective sign (sign_a for a, sign_b_eff for b).
  4. Both operands ZERO → special_result is a signed zero, sign = sign_a AND sign_b_eff (round-to-nearest rule).
  5. Otherwise → special_valid = 0, invalid = 0.
- Datapath storage: one output register set plus one skid register set of identical content. All decode is combinational before capture.
- Handshake state machine, derived from out_valid and skid_valid:
  - EMPTY (0,0): out_valid = 0, in_ready = 1. An accepted beat goes to the output register → HOLD.
  - HOLD (1,0): in_ready = 1.
    - Output taken with no input → EMPTY.
    - Output taken with an input accepted → new beat to output, stay HOLD.
    - Output not taken with an input accepted → beat to skid → FULL.
  - FULL (1,1): in_ready = 0. When the output is taken, skid moves to the output → HOLD.
- in_ready is driven directly from a register (= NOT skid_valid). There is no combinational path from out_ready to in_ready.
- Transfers occur on cycles where valid and ready are both 1. Beat order is preserved; no beat is dropped or duplicated.

## Timing
- Latency: 1 cycle from input acceptance to out_valid when the stage is empty.
- Throughput: 1 beat per cycle while out_ready = 1.
- Reset, on a clk edge with rst_n = 0:
  - out_valid = 0, skid_valid = 0.
  - All data outputs cleared to 0.
  - in_ready = 0 while rst_n is low, and 1 on the first cycle after release.
- Reset mid-operation discards both held beats. No partial beat appears after reset.
- Output fields stay stable while out_valid = 1 and out_ready = 0.
- A simultaneous take and accept in FULL cannot occur, because in_ready = 0 in that state.

## Test plan
- Normal operands: a=0x3F800000, b=0x40000000, op=0.
  - Next cycle: exp_a = 127, exp_b = 128, mant_a = mant_b = 0x800000.
  - class NORMAL/NORMAL, eff_sub = 0, special_valid = 0.
- Infinity minus infinity: a = b = 0x7F800000, op=1 → special_valid = 1, special_result = 0x7FC00000, invalid = 1.
- NaN operands: a=0x7F800001 (SNAN), b=0x3F800000 → special_result = 0x7FC00000, invalid = 1. Repeat with a=0x7FC00000 → invalid = 0.
- Zeros and denormals:
  - a=0x80000000, b=0x00000000, op=1 → special_result = 0x80000000.
  - a=0x00000001 → class DENORM, exp_a = 1, mant_a = 0x000001.
- Backpressure: 3 back-to-back beats with out_ready = 0.
  - Beat 1 is in the output, beat 2 in the skid; in_ready = 0 from the cycle after beat 2 is accepted.
  - Release out_ready → beats 1, 2, 3 emerge in order, no loss.
- Reset: assert rst_n = 0 while in FULL → out_valid = 0 on the next edge. After release, in_ready = 1 and a fresh beat appears with 1-cycle latency.
